// File: rtl/ssd_scan_if.sv
// ssd_scan_if: host-side bundle for the seven-segment scan controller.
//   load/value_in/blank_in : host -> controller (one-cycle load strobe)
//   out_SSD/an             : active-low segment and anode drives
//   digit_sel              : index of the digit slot currently being scanned
//   frame_tick             : one-cycle pulse when the scan wraps to digit 0
//   update_pending         : a loaded value is waiting for the next frame boundary
// master = host/testbench side, slave = controller side.
interface ssd_scan_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int SW = $clog2(NUM_DIGITS);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [6:0]              out_SSD;
  logic [NUM_DIGITS-1:0]   an;
  logic [SW-1:0]           digit_sel;
  logic                    frame_tick;
  logic                    update_pending;

  modport master (
    output load, value_in, blank_in,
    input  out_SSD, an, digit_sel, frame_tick, update_pending
  );

  modport slave (
    input  load, value_in, blank_in,
    output out_SSD, an, digit_sel, frame_tick, update_pending
  );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit seven-segment display.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : ssd_scan_if.slave (load strobe, value/blank inputs,
//                segment/anode outputs, digit_sel, frame_tick, update_pending)
// A loaded value sits in a pending register and is committed to the display
// register only on the frame-wrap cycle, so a frame never mixes two values.
// The output stage is registered and lags the prescaler/digit_sel by one cycle.
// Optional feature: define SSD_LEADING_ZERO_BLANK_EN to blank digits above the
// most-significant nonzero nibble (digit 0 always shown unless blank_in masks it).
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic      clk,
  input logic      reset,
  ssd_scan_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         digit_sel_q, digit_sel_d;
  logic [VW-1:0]         disp_val_q, disp_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] disp_blank_q, disp_blank_d, pend_blank_q, pend_blank_d;
  logic                  pending_q, pending_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  last_slot, wrap, in_blank, dig_dark;
  logic [3:0]            nib;
  logic [SW-1:0]         msd;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  // Anti-ghosting window at the start of each slot; a zero-length window
  // elaborates to a constant so no degenerate compare is built.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (presc_q < PW'(BLANK_CYCLES));
  end

  always_comb begin
    last_slot    = (presc_q == PW'(REFRESH_DIV - 1));
    wrap         = last_slot && (digit_sel_q == SW'(NUM_DIGITS - 1));
    presc_d      = last_slot ? '0 : presc_q + PW'(1);
    digit_sel_d  = digit_sel_q;
    if (last_slot) digit_sel_d = wrap ? '0 : digit_sel_q + SW'(1);
    frame_tick_d = wrap;

    // Commit uses the pending value as it stood before this cycle's load,
    // so a load on the wrap cycle lands in pending and stays flagged.
    disp_val_d   = disp_val_q;
    disp_blank_d = disp_blank_q;
    if (wrap && pending_q) begin
      disp_val_d   = pend_val_q;
      disp_blank_d = pend_blank_q;
    end
    pend_val_d   = pend_val_q;
    pend_blank_d = pend_blank_q;
    if (bus.load) begin
      pend_val_d   = bus.value_in;
      pend_blank_d = bus.blank_in;
    end
    pending_d = bus.load || (pending_q && !wrap);

    nib      = 4'h0;
    dig_dark = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_sel_q == SW'(i)) begin
        nib      = disp_val_q[4*i +: 4];
        dig_dark = disp_blank_q[i];
      end
    end

    msd = '0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    for (int i = 1; i < NUM_DIGITS; i++)
      if (disp_val_q[4*i +: 4] != 4'h0) msd = SW'(i);
    if (digit_sel_q > msd) dig_dark = 1'b1;
`endif

    an_d  = '1;
    seg_d = 7'b1111111;
    if (!in_blank && !dig_dark) begin
      for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = (digit_sel_q != SW'(i));
      seg_d = hex7(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      digit_sel_q  <= '0;
      disp_val_q   <= '0;
      disp_blank_q <= '0;
      pend_val_q   <= '0;
      pend_blank_q <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= 7'b1111111;
      an_q         <= '1;
    end else begin
      presc_q      <= presc_d;
      digit_sel_q  <= digit_sel_d;
      disp_val_q   <= disp_val_d;
      disp_blank_q <= disp_blank_d;
      pend_val_q   <= pend_val_d;
      pend_blank_q <= pend_blank_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign bus.out_SSD        = seg_q;
  assign bus.an             = an_q;
  assign bus.digit_sel      = digit_sel_q;
  assign bus.frame_tick     = frame_tick_q;
  assign bus.update_pending = pending_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: two instances (BLANK_CYCLES=1 and 0) share stimulus.
// A cycle-count based reference model predicts every output each cycle; a
// directed vector table covers reset/first cycles; hand sequences cover
// commit timing, load-on-commit, blanking and leading-zero blanking.
module tb_ssd_scan_ctrl;
  localparam int N = 4;
  localparam int R = 4;
  localparam int FR = N * R;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld = 1'b0;
  logic [15:0] val = '0;
  logic [3:0]  blk = '0;

  always #5 clk = ~clk;

  ssd_scan_if #(.NUM_DIGITS(N)) if1 ();
  ssd_scan_if #(.NUM_DIGITS(N)) if2 ();
  assign if1.load = ld;  assign if1.value_in = val;  assign if1.blank_in = blk;
  assign if2.load = ld;  assign if2.value_in = val;  assign if2.blank_in = blk;

  ssd_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(1)) dut1 (.clk(clk), .reset(rst), .bus(if1));
  ssd_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(0)) dut2 (.clk(clk), .reset(rst), .bus(if2));

  int nchk = 0;
  int nerr = 0;

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Model state: t = clock edges since reset release; slot/digit derive from t.
  typedef struct {
    int          t;
    logic [15:0] dv, pv;
    logic [3:0]  db, pb;
    logic        up;
  } ms_t;
  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] dsel;
    logic       ft, up;
  } ex_t;

  ms_t m1, m2;
  ex_t e1, e2;

  task automatic model_step(input int bc, input ms_t si, output ms_t so, output ex_t e);
    int pres, dig, top;
    logic wrap, dark;
    so = si;
    if (rst) begin
      so = '{0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b0};
      e  = '{7'h7F, 4'hF, 2'd0, 1'b0, 1'b0};
      return;
    end
    pres = si.t % R;
    dig  = (si.t / R) % N;
    wrap = (si.t % FR) == FR - 1;
    dark = (pres < bc) || si.db[dig];
`ifdef SSD_LEADING_ZERO_BLANK_EN
    top = 0;
    for (int i = 0; i < N; i++) if (si.dv[4*i +: 4] != 4'h0) top = i;
    if (dig > top) dark = 1'b1;
`else
    top = 0;
`endif
    e.an  = dark ? 4'hF : ~(4'b0001 << dig);
    e.seg = dark ? 7'h7F : seg_tab[si.dv[4*dig +: 4]];
    if (wrap && si.up) begin so.dv = si.pv; so.db = si.pb; end
    if (ld) begin so.pv = val; so.pb = blk; end
    so.up  = ld || (si.up && !wrap);
    so.t   = si.t + 1;
    e.ft   = wrap;
    e.dsel = 2'((so.t / R) % N);
    e.up   = so.up;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    model_step(1, m1, m1, e1);
    model_step(0, m2, m2, e2);
    chk("d1_seg",  16'(if1.out_SSD),        16'(e1.seg));
    chk("d1_an",   16'(if1.an),             16'(e1.an));
    chk("d1_dsel", 16'(if1.digit_sel),      16'(e1.dsel));
    chk("d1_ft",   16'(if1.frame_tick),     16'(e1.ft));
    chk("d1_up",   16'(if1.update_pending), 16'(e1.up));
    chk("d2_seg",  16'(if2.out_SSD),        16'(e2.seg));
    chk("d2_an",   16'(if2.an),             16'(e2.an));
    chk("d2_dsel", 16'(if2.digit_sel),      16'(e2.dsel));
    chk("d2_ft",   16'(if2.frame_tick),     16'(e2.ft));
    chk("d2_up",   16'(if2.update_pending), 16'(e2.up));
  endtask

  // Frame observation, aligned so that it covers one full display frame.
  logic [6:0] seen_seg [N];
  int lit_cnt [N];
  int dark1, dark2, ticks;

  task automatic run_frame();
    dark1 = 0; dark2 = 0; ticks = 0;
    for (int d = 0; d < N; d++) begin lit_cnt[d] = 0; seen_seg[d] = 7'h7F; end
    for (int c = 0; c < FR; c++) begin
      step();
      for (int d = 0; d < N; d++)
        if (if1.an[d] == 1'b0) begin lit_cnt[d]++; seen_seg[d] = if1.out_SSD; end
      if (if1.an == 4'hF) dark1++;
      if (if2.an == 4'hF) dark2++;
      if (if1.frame_tick) ticks++;
    end
  endtask

  task automatic run_to_commit();
    do step(); while (m1.t % FR != 0);
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] b);
    ld = 1'b1; val = v; blk = b;
    step();
    ld = 1'b0;
  endtask

  typedef struct {
    logic rst, ld;
    logic [15:0] v;
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] ds;
    logic ft, up;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 7'h7F, 4'hF, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h0000, 7'h7F, 4'hF, 2'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 16'h0000, 7'h7F, 4'hF, 2'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 16'h1234, 7'h7F, 4'hF, 2'd0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 16'h1234, 7'h01, 4'hE, 2'd0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 16'h1234, 7'h01, 4'hE, 2'd0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 16'h1234, 7'h01, 4'hE, 2'd1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 16'h1234, 7'h7F, 4'hF, 2'd1, 1'b0, 1'b1};

    m1 = '{0, 16'h0, 16'h0, 4'h0, 4'h0, 1'b0};
    m2 = m1;
    #2;
    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst; ld = tbl[i].ld; val = tbl[i].v; blk = 4'h0;
      step();
      chk("tbl_seg",  16'(if1.out_SSD),        16'(tbl[i].seg));
      chk("tbl_an",   16'(if1.an),             16'(tbl[i].an));
      chk("tbl_dsel", 16'(if1.digit_sel),      16'(tbl[i].ds));
      chk("tbl_ft",   16'(if1.frame_tick),     16'(tbl[i].ft));
      chk("tbl_up",   16'(if1.update_pending), 16'(tbl[i].up));
    end
    ld = 1'b0;

    // 1234 commits at the first wrap, then shows 4,3,2,1 on digits 0..3
    run_to_commit();
    chk("commit_up_clear", 16'(if1.update_pending), 16'd0);
    run_frame();
    chk("f1234_d0", 16'(seen_seg[0]), 16'(7'b1001100));
    chk("f1234_d1", 16'(seen_seg[1]), 16'(7'b0000110));
    chk("f1234_d2", 16'(seen_seg[2]), 16'(7'b0010010));
    chk("f1234_d3", 16'(seen_seg[3]), 16'(7'b1001111));
    chk("f1234_ticks", 16'(ticks), 16'd1);
    chk("f1234_dark_bc1", 16'(dark1), 16'(N));
    chk("f1234_dark_bc0", 16'(dark2), 16'd0);

    // ABCD loaded mid-frame: pending until the wrap, then d,C,b,A
    step(); step(); step();
    load_val(16'hABCD, 4'h0);
    chk("abcd_pending", 16'(if1.update_pending), 16'd1);
    run_to_commit();
    chk("abcd_up_clear", 16'(if1.update_pending), 16'd0);
    run_frame();
    chk("fabcd_d0", 16'(seen_seg[0]), 16'(7'b1000010));
    chk("fabcd_d1", 16'(seen_seg[1]), 16'(7'b0110001));
    chk("fabcd_d2", 16'(seen_seg[2]), 16'(7'b1100000));
    chk("fabcd_d3", 16'(seen_seg[3]), 16'(7'b0001000));

    // 0001 then 00F0 exactly on the commit cycle
    step(); step();
    load_val(16'h0001, 4'h0);
    while (m1.t % FR != FR - 1) step();
    load_val(16'h00F0, 4'h0);
    chk("loc_up_held", 16'(if1.update_pending), 16'd1);
    run_frame();
    chk("f0001_d0", 16'(seen_seg[0]), 16'(7'b1001111));
    chk("f0001_up_clear", 16'(if1.update_pending), 16'd0);
    run_frame();
    chk("f00f0_d0", 16'(seen_seg[0]), 16'(7'b0000001));
    chk("f00f0_d1", 16'(seen_seg[1]), 16'(7'b0111000));

    // blank_in masks digits 1 and 3
    load_val(16'h8888, 4'b1010);
    run_to_commit();
    run_frame();
    chk("blk_d1_off", 16'(lit_cnt[1]), 16'd0);
    chk("blk_d3_off", 16'(lit_cnt[3]), 16'd0);
    chk("blk_d0_lit", 16'(lit_cnt[0]), 16'(R - 1));
    chk("blk_d0_seg", 16'(seen_seg[0]), 16'(7'b0000000));

`ifdef SSD_LEADING_ZERO_BLANK_EN
    load_val(16'h0050, 4'h0);
    run_to_commit();
    run_frame();
    chk("lzb50_d2", 16'(lit_cnt[2]), 16'd0);
    chk("lzb50_d3", 16'(lit_cnt[3]), 16'd0);
    chk("lzb50_d1", 16'(seen_seg[1]), 16'(7'b0100100));
    load_val(16'h0000, 4'h0);
    run_to_commit();
    run_frame();
    chk("lzb0_d0", 16'(seen_seg[0]), 16'(7'b0000001));
    chk("lzb0_others", 16'(lit_cnt[1] + lit_cnt[2] + lit_cnt[3]), 16'd0);
`endif

    // reset mid-frame with a pending load discards everything
    step(); step();
    load_val(16'h4321, 4'h0);
    step();
    rst = 1'b1;
    step();
    chk("mrst_seg", 16'(if1.out_SSD), 16'h7F);
    chk("mrst_an",  16'(if1.an), 16'hF);
    chk("mrst_up",  16'(if1.update_pending), 16'd0);
    chk("mrst_ds",  16'(if1.digit_sel), 16'd0);
    rst = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      val = 16'($urandom);
      blk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step();
    end
    rst = 1'b0; ld = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
